n_bit_mux: RTL and testbench

- Parameterised N-bit, 4-to-1 data multiplexer with a registered output.
- Selects one of four N-bit words (A, B, C, D) by a 2-bit select S and presents it on Y one clock after capture.
- Used wherever a datapath must pick one of four equal-width sources on a clock boundary.
- Includes a simple valid qualifier so downstream logic knows when Y is fresh.

---
 rtl/n_bit_mux_pkg.sv | 11 +
 rtl/n_bit_mux_if.sv | 27 ++
 rtl/n_bit_mux_mux4_comb.sv | 26 ++
 rtl/n_bit_mux.sv | 38 +++
 tb/tb_n_bit_mux.sv | 139 +++++++++++++
 5 files changed

// File: rtl/n_bit_mux_pkg.sv
// Shared constants for the n_bit_mux slice: select encodings and default width.
package n_bit_mux_pkg;

    localparam int MUX_DEFAULT_N = 8;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/n_bit_mux_if.sv
// Bus bundle for n_bit_mux: four equal-width sources, select, strobe and registered result.
interface n_bit_mux_if
    import n_bit_mux_pkg::*;
#(
    parameter int N = MUX_DEFAULT_N
);

    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic [N-1:0] D;
    logic [1:0]   S;
    logic         in_valid;
    logic [N-1:0] Y;
    logic         out_valid;

    modport master (
        output A, B, C, D, S, in_valid,
        input  Y, out_valid
    );

    modport slave (
        input  A, B, C, D, S, in_valid,
        output Y, out_valid
    );

endinterface

// File: rtl/n_bit_mux_mux4_comb.sv
// Purely combinational N-bit 4:1 selector; every select code is decoded, so no latch.
module mux4_comb
    import n_bit_mux_pkg::*;
#(
    parameter int N = MUX_DEFAULT_N
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic [1:0]   S,
    output logic [N-1:0] sel
);

    always_comb begin
        sel = A;
        case (S)
            SEL_A: sel = A;
            SEL_B: sel = B;
            SEL_C: sel = C;
            SEL_D: sel = D;
            default: sel = A;
        endcase
    end

endmodule

// File: rtl/n_bit_mux.sv
// N-bit 4:1 mux with a registered output and a one-cycle valid qualifier.
module n_bit_mux
    import n_bit_mux_pkg::*;
#(
    parameter int N = MUX_DEFAULT_N
) (
    input  logic        clk,
    input  logic        rst_n,
    n_bit_mux_if.slave  bus
);

    logic [N-1:0] sel;

    mux4_comb #(
        .N (N)
    ) u_mux4_comb (
        .A   (bus.A),
        .B   (bus.B),
        .C   (bus.C),
        .D   (bus.D),
        .S   (bus.S),
        .sel (sel)
    );

    // Y only moves on a strobed edge; out_valid simply follows the strobe by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.Y         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.Y <= sel;
            end
        end
    end

endmodule

// File: tb/tb_n_bit_mux.sv
// Self-checking bench: N=8, N=16 and N=1 instances driven in lockstep against an array-based reference.
module tb_n_bit_mux;
    import n_bit_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    n_bit_mux_if #(.N(8))  bus8  ();
    n_bit_mux_if #(.N(16)) bus16 ();
    n_bit_mux_if #(.N(1))  bus1  ();

    n_bit_mux #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    n_bit_mux #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    n_bit_mux #(.N(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int errors = 0;

    logic [7:0]  src8  [4];
    logic [15:0] src16 [4];
    logic        src1  [4];
    logic [1:0]  s16;
    logic [1:0]  s1;
    bit          randomize_wide;

    logic [7:0]  exp_y8;
    logic [15:0] exp_y16;
    logic        exp_y1;
    logic        exp_v;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it in, advance the reference and compare all three instances.
    task automatic applyStimulus(input logic rst, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] d, input logic [1:0] s,
                                 input logic iv, input string tag);
        src8[0] = a; src8[1] = b; src8[2] = c; src8[3] = d;
        if (randomize_wide) begin
            for (int i = 0; i < 4; i++) begin
                src16[i] = 16'($urandom);
                src1[i]  = 1'($urandom);
            end
            s16 = 2'($urandom);
            s1  = 2'($urandom);
        end
        rst_n = rst;
        bus8.A = src8[0];   bus8.B = src8[1];   bus8.C = src8[2];   bus8.D = src8[3];
        bus8.S = s;         bus8.in_valid = iv;
        bus16.A = src16[0]; bus16.B = src16[1]; bus16.C = src16[2]; bus16.D = src16[3];
        bus16.S = s16;      bus16.in_valid = iv;
        bus1.A = src1[0];   bus1.B = src1[1];   bus1.C = src1[2];   bus1.D = src1[3];
        bus1.S = s1;        bus1.in_valid = iv;

        @(posedge clk);
        #1;

        if (!rst) begin
            exp_y8  = '0;
            exp_y16 = '0;
            exp_y1  = 1'b0;
            exp_v   = 1'b0;
        end else begin
            exp_v = iv;
            if (iv) begin
                exp_y8  = src8[s];
                exp_y16 = src16[s16];
                exp_y1  = src1[s1];
            end
        end

        checkOutput({tag, "/y8"},  32'(bus8.Y),          32'(exp_y8));
        checkOutput({tag, "/v8"},  32'(bus8.out_valid),  32'(exp_v));
        checkOutput({tag, "/y16"}, 32'(bus16.Y),         32'(exp_y16));
        checkOutput({tag, "/v16"}, 32'(bus16.out_valid), 32'(exp_v));
        checkOutput({tag, "/y1"},  32'(bus1.Y),          32'(exp_y1));
        checkOutput({tag, "/v1"},  32'(bus1.out_valid),  32'(exp_v));
    endtask

    initial begin
        randomize_wide = 1'b1;
        $display("[TB] start");

        applyStimulus(1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, SEL_A, 1'b1, "rst0");
        applyStimulus(1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, SEL_A, 1'b1, "rst1");
        checkOutput("rst_literal_y", 32'(bus8.Y), 32'h00);
        applyStimulus(1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, SEL_A, 1'b1, "rst_release");
        checkOutput("rst_release_literal_y", 32'(bus8.Y), 32'hFF);

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 8'h0F, 8'hF0, 8'h55, 8'hAA, 2'(i), 1'b1, "set1");
        checkOutput("set1_last_literal", 32'(bus8.Y), 32'hAA);

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 8'hFF, 8'h00, 8'hA5, 8'h5A, 2'(i), 1'b1, "set2");
        checkOutput("set2_last_literal", 32'(bus8.Y), 32'h5A);

        applyStimulus(1'b1, 8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_D, 1'b1, "hold_cap");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h12, 8'hF0, 8'h55, 8'hAA, SEL_A, 1'b0, "hold");
            checkOutput("hold_literal_y", 32'(bus8.Y), 32'hAA);
        end

        applyStimulus(1'b1, 8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_A, 1'b1, "mid_s0");
        applyStimulus(1'b1, 8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_B, 1'b1, "mid_s1");
        applyStimulus(1'b0, 8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_C, 1'b1, "mid_rst");
        applyStimulus(1'b1, 8'h0F, 8'hF0, 8'h55, 8'hAA, SEL_D, 1'b1, "mid_release");
        checkOutput("mid_release_literal_y", 32'(bus8.Y), 32'hAA);

        randomize_wide = 1'b0;
        src16[0] = 16'h1234; src16[1] = 16'h5678; src16[2] = 16'h9ABC; src16[3] = 16'hBEEF;
        src1[0] = 1'b0; src1[1] = 1'b1; src1[2] = 1'b0; src1[3] = 1'b1;
        s16 = SEL_A; s1 = SEL_B;
        applyStimulus(1'b1, 8'h01, 8'h02, 8'h03, 8'h04, SEL_A, 1'b1, "wide_a");
        checkOutput("wide_a_literal", 32'(bus16.Y), 32'h1234);
        s16 = SEL_D; s1 = SEL_C;
        applyStimulus(1'b1, 8'h01, 8'h02, 8'h03, 8'h04, SEL_D, 1'b1, "wide_d");
        checkOutput("wide_d_literal", 32'(bus16.Y), 32'hBEEF);
        checkOutput("narrow_literal", 32'(bus1.Y), 32'h0);
        randomize_wide = 1'b1;

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0),
                          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                          2'($urandom), 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
